// File: rtl/usb_data_buffer_if.sv
// Bus bundle between the 64-byte endpoint buffer and its AHB / USB RX / USB TX users.
// The buffer connects to the slave modport; the user side drives the master modport.
interface usb_data_buffer_if #(
   parameter int OCC_W = 7
);
   logic             clear;
   logic             store_tx_data;
   logic [7:0]       tx_data;
   logic             get_rx_data;
   logic [7:0]       rx_data;
   logic             store_rx_data;
   logic [7:0]       rx_packet_data;
   logic             get_tx_packet_data;
   logic [7:0]       tx_packet_data;
   logic [OCC_W-1:0] buffer_occupancy;
   logic             overflow;
   logic             underflow;
   logic             collision;

   modport master (
      output clear, store_tx_data, tx_data, get_rx_data, store_rx_data,
             rx_packet_data, get_tx_packet_data,
      input  rx_data, tx_packet_data, buffer_occupancy, overflow, underflow, collision
   );

   modport slave (
      input  clear, store_tx_data, tx_data, get_rx_data, store_rx_data,
             rx_packet_data, get_tx_packet_data,
      output rx_data, tx_packet_data, buffer_occupancy, overflow, underflow, collision
   );
endinterface

// File: rtl/usb_data_buffer.sv
// Shared endpoint byte FIFO with show-ahead head byte, occupancy count and
// single-cycle registered error pulses (overflow, underflow, strobe collision).
module usb_data_buffer #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6,
   parameter int OCC_W  = 7
) (
   input logic              clk,
   input logic              n_rst,
   usb_data_buffer_if.slave bus
);
   logic [7:0]        mem_r [DEPTH];
   logic [ADDR_W-1:0] wPtr_r;
   logic [ADDR_W-1:0] rPtr_r;
   logic [OCC_W-1:0]  count_r;
   logic              overflow_r;
   logic              underflow_r;
   logic              collision_r;

   logic              pushReq_s;
   logic              popReq_s;
   logic              full_s;
   logic              empty_s;
   logic              pushAcc_s;
   logic              popAcc_s;
   logic [7:0]        pushData_s;
   logic [7:0]        headByte_s;
   logic [OCC_W-1:0]  countNext_s;

   assign pushReq_s = bus.store_tx_data | bus.store_rx_data;
   assign popReq_s  = bus.get_rx_data | bus.get_tx_packet_data;
   assign full_s    = (count_r == OCC_W'(DEPTH));
   assign empty_s   = (count_r == {OCC_W{1'b0}});
   // A full buffer still accepts a push when a pop frees the head slot in the same cycle.
   assign pushAcc_s = pushReq_s & (~full_s | popReq_s);
   assign popAcc_s  = popReq_s & ~empty_s;

   // Push data select and next occupancy.
   always_comb begin
      pushData_s  = 8'h00;
      countNext_s = count_r;
      if (bus.store_tx_data) begin
         pushData_s = bus.tx_data;
      end else begin
         pushData_s = bus.rx_packet_data;
      end
      case ({pushAcc_s, popAcc_s})
         2'b10:   countNext_s = count_r + OCC_W'(1);
         2'b01:   countNext_s = count_r - OCC_W'(1);
         default: countNext_s = count_r;
      endcase
   end

   // Show-ahead head byte, forced to zero while empty.
   always_comb begin
      headByte_s = 8'h00;
      if (empty_s) begin
         headByte_s = 8'h00;
      end else begin
         headByte_s = mem_r[rPtr_r];
      end
   end

   // Byte storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (pushAcc_s && !bus.clear) begin
         mem_r[wPtr_r] <= pushData_s;
      end
   end

   // Pointers, occupancy and error pulses; clear flushes and suppresses every strobe.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wPtr_r      <= {ADDR_W{1'b0}};
         rPtr_r      <= {ADDR_W{1'b0}};
         count_r     <= {OCC_W{1'b0}};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
         collision_r <= 1'b0;
      end else if (bus.clear) begin
         wPtr_r      <= {ADDR_W{1'b0}};
         rPtr_r      <= {ADDR_W{1'b0}};
         count_r     <= {OCC_W{1'b0}};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
         collision_r <= 1'b0;
      end else begin
         if (pushAcc_s) begin
            wPtr_r <= wPtr_r + ADDR_W'(1);
         end
         if (popAcc_s) begin
            rPtr_r <= rPtr_r + ADDR_W'(1);
         end
         count_r     <= countNext_s;
         overflow_r  <= pushReq_s & full_s & ~popReq_s;
         underflow_r <= popReq_s & empty_s;
         collision_r <= (bus.store_tx_data & bus.store_rx_data) |
                        (bus.get_rx_data & bus.get_tx_packet_data);
      end
   end

   assign bus.rx_data          = headByte_s;
   assign bus.tx_packet_data   = headByte_s;
   assign bus.buffer_occupancy = count_r;
   assign bus.overflow         = overflow_r;
   assign bus.underflow        = underflow_r;
   assign bus.collision        = collision_r;
endmodule
